// File: rtl/vga_sprite_engine.sv
// VGA timing generator with NOBJ bouncing square sprites and a two-stage pixel pipeline.
// Optional one-pixel white frame border is compiled in with `define VGA_SPRITE_BORDER_EN.
module vga_sprite_engine #(
    parameter int HWIDTH  = 640,
    parameter int HFPORCH = 16,
    parameter int HSYNC   = 96,
    parameter int HBPORCH = 48,
    parameter int VWIDTH  = 480,
    parameter int VFPORCH = 11,
    parameter int VSYNC   = 2,
    parameter int VBPORCH = 31,
    parameter int NOBJ    = 4,
    parameter int SIZE    = 30,
    parameter int STEP    = 5,
    parameter int CBITS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    output logic [CBITS-1:0] VGA_R,
    output logic [CBITS-1:0] VGA_G,
    output logic [CBITS-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE,
    output logic [15:0]      frame_cnt
);

    localparam int HTOTAL = HWIDTH + HFPORCH + HSYNC + HBPORCH;
    localparam int VTOTAL = VWIDTH + VFPORCH + VSYNC + VBPORCH;
    localparam int HCW    = $clog2(HTOTAL);
    localparam int VCW    = $clog2(VTOTAL);
    localparam int PW     = 16;
    localparam int PXW    = 3 + 3 * CBITS;
    localparam logic [PXW-1:0] PIX_RST = {1'b1, 1'b1, 1'b0, {(3 * CBITS){1'b0}}};

    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           strobe_s;
    logic           move_s;

    logic [PW-1:0]  x_q [NOBJ];
    logic [PW-1:0]  x_d [NOBJ];
    logic [PW-1:0]  y_q [NOBJ];
    logic [PW-1:0]  y_d [NOBJ];
    logic [NOBJ-1:0] dx_q, dx_d, dy_q, dy_d;

    logic [PW-1:0]  hx_s, vy_s;
    logic [NOBJ-1:0] cov_s;
    logic           hit_s, hs_s, vs_s, de_s;
    logic [3*CBITS-1:0] obj_rgb_s, pix_rgb_s;
    logic [PXW-1:0] p1_q, p1_d, p2_q, p2_d;

    // Object colour: R/G/B full-scale from bits 0/1/2 of (index+1), packed {R,G,B}.
    function automatic logic [3*CBITS-1:0] obj_colour(input int idx);
        logic [2:0] code;
        code = 3'(idx + 1);
        return {{CBITS{code[0]}}, {CBITS{code[1]}}, {CBITS{code[2]}}};
    endfunction

    assign strobe_s = (hcnt_q == {HCW{1'b0}}) && (vcnt_q == VCW'(VWIDTH));
    assign move_s   = strobe_s && !pause;

    // Raster counters and completed-frame counter next-state.
    always_comb begin
        if (hcnt_q == HCW'(HTOTAL - 1)) begin
            hcnt_d = {HCW{1'b0}};
            if (vcnt_q == VCW'(VTOTAL - 1)) begin
                vcnt_d = {VCW{1'b0}};
            end else begin
                vcnt_d = vcnt_q + VCW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HCW'(1);
            vcnt_d = vcnt_q;
        end
        if (strobe_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Object motion: bounce each sprite off the visible-area edges once per frame.
    always_comb begin
        for (int i = 0; i < NOBJ; i++) begin
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            dx_d[i] = dx_q[i];
            dy_d[i] = dy_q[i];
            if (move_s) begin
                if (!dx_q[i]) begin
                    if (x_q[i] + PW'(SIZE + STEP + i) > PW'(HWIDTH - 1)) begin
                        x_d[i]  = PW'(HWIDTH - 1 - SIZE);
                        dx_d[i] = 1'b1;
                    end else begin
                        x_d[i]  = x_q[i] + PW'(STEP + i);
                    end
                end else begin
                    if (x_q[i] < PW'(SIZE + STEP + i)) begin
                        x_d[i]  = PW'(SIZE);
                        dx_d[i] = 1'b0;
                    end else begin
                        x_d[i]  = x_q[i] - PW'(STEP + i);
                    end
                end
                if (!dy_q[i]) begin
                    if (y_q[i] + PW'(SIZE + STEP) > PW'(VWIDTH - 1)) begin
                        y_d[i]  = PW'(VWIDTH - 1 - SIZE);
                        dy_d[i] = 1'b1;
                    end else begin
                        y_d[i]  = y_q[i] + PW'(STEP);
                    end
                end else begin
                    if (y_q[i] < PW'(SIZE + STEP)) begin
                        y_d[i]  = PW'(SIZE);
                        dy_d[i] = 1'b0;
                    end else begin
                        y_d[i]  = y_q[i] - PW'(STEP);
                    end
                end
            end else begin
                x_d[i]  = x_q[i];
                y_d[i]  = y_q[i];
            end
        end
    end

    assign hx_s = PW'(hcnt_q);
    assign vy_s = PW'(vcnt_q);

    // Coverage test written as h+SIZE >= x so no subtraction can underflow.
    always_comb begin
        for (int i = 0; i < NOBJ; i++) begin
            cov_s[i] = (hx_s + PW'(SIZE) >= x_q[i]) && (hx_s <= x_q[i] + PW'(SIZE)) &&
                       (vy_s + PW'(SIZE) >= y_q[i]) && (vy_s <= y_q[i] + PW'(SIZE));
        end
    end

    // Pixel stage-1 value: sync, enable and prioritised colour for the current counters.
    always_comb begin
        hit_s     = 1'b0;
        obj_rgb_s = {(3 * CBITS){1'b0}};
        for (int i = NOBJ - 1; i >= 0; i--) begin
            hit_s     = hit_s | cov_s[i];
            obj_rgb_s = cov_s[i] ? obj_colour(i) : obj_rgb_s;
        end
        hs_s = !((hcnt_q >= HCW'(HWIDTH + HFPORCH)) && (hcnt_q < HCW'(HWIDTH + HFPORCH + HSYNC)));
        vs_s = !((vcnt_q >= VCW'(VWIDTH + VFPORCH)) && (vcnt_q < VCW'(VWIDTH + VFPORCH + VSYNC)));
        de_s = (hcnt_q < HCW'(HWIDTH)) && (vcnt_q < VCW'(VWIDTH));
        if (!de_s) begin
            pix_rgb_s = {(3 * CBITS){1'b0}};
        end
`ifdef VGA_SPRITE_BORDER_EN
        else if ((hcnt_q == {HCW{1'b0}}) || (hcnt_q == HCW'(HWIDTH - 1)) ||
                 (vcnt_q == {VCW{1'b0}}) || (vcnt_q == VCW'(VWIDTH - 1))) begin
            pix_rgb_s = {(3 * CBITS){1'b1}};
        end
`endif
        else if (hit_s) begin
            pix_rgb_s = obj_rgb_s;
        end else begin
            pix_rgb_s = {(3 * CBITS){1'b0}};
        end
        p1_d = {hs_s, vs_s, de_s, pix_rgb_s};
        p2_d = p1_q;
    end

    // Counters, pipeline and frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= {HCW{1'b0}};
            vcnt_q      <= {VCW{1'b0}};
            frame_cnt_q <= 16'd0;
            p1_q        <= PIX_RST;
            p2_q        <= PIX_RST;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
        end
    end

    // Object state registers; reset staggers the sprites diagonally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOBJ; i++) begin
                x_q[i]  <= PW'(SIZE + 16 * i);
                y_q[i]  <= PW'(SIZE + 8 * i);
                dx_q[i] <= 1'((i >> 0) & 1);
                dy_q[i] <= 1'((i >> 1) & 1);
            end
        end else begin
            for (int i = 0; i < NOBJ; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    assign VGA_HS    = p2_q[PXW-1];
    assign VGA_VS    = p2_q[PXW-2];
    assign VGA_DE    = p2_q[PXW-3];
    assign VGA_R     = p2_q[3*CBITS-1:2*CBITS];
    assign VGA_G     = p2_q[2*CBITS-1:CBITS];
    assign VGA_B     = p2_q[CBITS-1:0];
    assign frame_cnt = frame_cnt_q;

endmodule
